// File: rtl/pc_fetch_gen_pkg.sv
// Shared constants and state encoding for the IF-stage fetch address generator.
package pc_fetch_gen_pkg;

   localparam int unsigned PCF_ADDR_W     = 32;
   localparam int unsigned PCF_INST_BYTES = 4;
   localparam int unsigned PCF_STALL_W    = 6;

   // Reset is active-low in this block's clock domain
   localparam logic RstEnable   = 1'b0;
   localparam logic ChipEnable  = 1'b1;
   localparam logic ChipDisable = 1'b0;
   localparam logic Stop        = 1'b1;
   localparam logic NoStop      = 1'b0;

   typedef enum logic [1:0] {
      PCF_BOOT  = 2'd0,
      PCF_FETCH = 2'd1,
      PCF_HOLD  = 2'd2
   } pcf_state_e;

endpackage

// File: rtl/pc_fetch_gen_if.sv
// Fetch request/ack bus between the PC generator and instruction memory.
interface pc_fetch_gen_if
   import pc_fetch_gen_pkg::*;
#(
   parameter int unsigned ADDR_W = PCF_ADDR_W
);
   logic              if_req_o;
   logic              if_ack_i;
   logic [ADDR_W-1:0] pc;
   logic              ce;

   modport master (output if_req_o, output pc, output ce, input  if_ack_i);
   modport slave  (input  if_req_o, input  pc, input  ce, output if_ack_i);
endinterface

// File: rtl/pc_fetch_gen_redirect_buf.sv
// One-entry pending redirect register; a pending flush is never displaced by a branch.
module pc_redirect_buf
   import pc_fetch_gen_pkg::*;
#(
   parameter int unsigned ADDR_W = PCF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_flush,
   input  logic [ADDR_W-1:0] i_flush_target,
   input  logic              i_branch,
   input  logic [ADDR_W-1:0] i_branch_target,
   input  logic              i_clear,
   output logic              o_valid,
   output logic [ADDR_W-1:0] o_target
);

   logic              r_valid;
   logic              r_is_flush;
   logic [ADDR_W-1:0] r_target;

   always_ff @(posedge clk or negedge rst) begin
      if (rst == RstEnable) begin
         r_valid    <= 1'b0;
         r_is_flush <= 1'b0;
         r_target   <= '0;
      end else if (i_clear) begin
         r_valid    <= 1'b0;
         r_is_flush <= 1'b0;
      end else if (i_flush) begin
         r_valid    <= 1'b1;
         r_is_flush <= 1'b1;
         r_target   <= i_flush_target;
      end else if (i_branch && !(r_valid && r_is_flush)) begin
         r_valid    <= 1'b1;
         r_is_flush <= 1'b0;
         r_target   <= i_branch_target;
      end
   end

   assign o_valid  = r_valid;
   assign o_target = r_target;

endmodule

// File: rtl/pc_fetch_gen.sv
// IF-stage program counter: fetch handshake, stall handling and prioritised redirects.
module pc_fetch_gen
   import pc_fetch_gen_pkg::*;
#(
   parameter int unsigned       ADDR_W     = PCF_ADDR_W,
   parameter logic [ADDR_W-1:0] RESET_VEC  = '0,
   parameter int unsigned       INST_BYTES = PCF_INST_BYTES,
   parameter int unsigned       STALL_W    = PCF_STALL_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall,
   input  logic               flush_i,
   input  logic [ADDR_W-1:0]  flush_target_i,
   input  logic               branch_flag_i,
   input  logic [ADDR_W-1:0]  branch_target_address_i,
   pc_fetch_gen_if.master     fetch_if,
   output logic               artificial,
   output logic               redirect_pending_o,
   output logic               misalign_o
);

   localparam logic [ADDR_W-1:0]  PcStep   = ADDR_W'(INST_BYTES);
   localparam logic [ADDR_W-1:0]  LowMask  = ADDR_W'(INST_BYTES - 1);
   localparam logic [STALL_W-1:0] FetchOnly = STALL_W'(1);

   pcf_state_e        r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_pc, w_pc_nxt;
   logic              r_req, w_req_nxt;
   logic              r_ce, w_ce_nxt;
   logic              r_art, r_mis;
   logic              w_clear, w_mis_nxt;

   logic              w_present, w_buf_valid, w_have_tgt;
   logic [ADDR_W-1:0] w_redirect, w_buf_target, w_tgt;

   assign w_present  = flush_i | branch_flag_i;
   assign w_redirect = flush_i ? flush_target_i : branch_target_address_i;
   assign w_have_tgt = w_present | w_buf_valid;
   assign w_tgt      = w_present ? w_redirect : w_buf_target;

   // Redirects are captured whenever the PC is not being reloaded this cycle
   pc_redirect_buf #(.ADDR_W(ADDR_W)) u_redirect_buf (
      .clk             (clk),
      .rst             (rst),
      .i_flush         (flush_i),
      .i_flush_target  (flush_target_i),
      .i_branch        (branch_flag_i),
      .i_branch_target (branch_target_address_i),
      .i_clear         (w_clear),
      .o_valid         (w_buf_valid),
      .o_target        (w_buf_target)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (rst == RstEnable) begin
         r_state <= PCF_BOOT;
         r_pc    <= RESET_VEC;
         r_req   <= 1'b0;
         r_ce    <= ChipDisable;
         r_art   <= 1'b0;
         r_mis   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_req   <= w_req_nxt;
         r_ce    <= w_ce_nxt;
         r_art   <= (stall == FetchOnly);
         r_mis   <= w_mis_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_req_nxt   = r_req;
      w_ce_nxt    = r_ce;
      w_clear     = 1'b0;
      case (r_state)
         PCF_BOOT: begin
            w_state_nxt = PCF_FETCH;
            w_req_nxt   = 1'b1;
            w_ce_nxt    = ChipEnable;
         end
         PCF_FETCH: begin
            // Address only moves once memory has taken the current request
            if (fetch_if.if_ack_i) begin
               w_clear  = 1'b1;
               w_pc_nxt = w_have_tgt ? w_tgt : r_pc + PcStep;
               if (stall[0] == Stop) begin
                  w_req_nxt   = 1'b0;
                  w_state_nxt = PCF_HOLD;
               end
            end
         end
         PCF_HOLD: begin
            if (stall[0] == NoStop) begin
               w_clear     = 1'b1;
               w_req_nxt   = 1'b1;
               w_state_nxt = PCF_FETCH;
               if (w_have_tgt) w_pc_nxt = w_tgt;
            end
         end
         default: begin
            w_state_nxt = PCF_BOOT;
            w_req_nxt   = 1'b0;
         end
      endcase
      w_mis_nxt = w_clear && w_have_tgt && ((w_tgt & LowMask) != '0);
   end

   assign fetch_if.pc       = r_pc;
   assign fetch_if.if_req_o = r_req;
   assign fetch_if.ce       = r_ce;
   assign artificial        = r_art;
   assign redirect_pending_o = w_buf_valid;
   assign misalign_o        = r_mis;

endmodule
